// File: rtl/frame_plotter.sv
// Raster sequencer: sweeps the play field through the background/sprite renderers,
// realigns their registered colours with the coordinates and writes composited pixels to VGA.
module frame_plotter #(
    parameter int X_MAX   = 160,
    parameter int Y_MAX   = 120,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] bgColor,
    input  logic [2:0] fgColor,
    input  logic       fgOpaque,
    output logic [7:0] scanX,
    output logic [7:0] scanY,
    output logic [7:0] vgaX,
    output logic [6:0] vgaY,
    output logic [2:0] vgaColor,
    output logic       plot,
    output logic       busy,
    output logic       frameDone
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [7:0] X_LAST     = 8'(X_MAX - 1);
    localparam logic [7:0] Y_LAST     = 8'(Y_MAX - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(LATENCY);

    state_t     state_q;
    logic [7:0] x_q, y_q;
    logic [2:0] cnt_q;
    logic       pending_q, busy_q, done_q;

    // DRAIN spends LATENCY+1 clocks flushing, then one more clock with frameDone high;
    // the next frame (if queued) issues its first coordinate after that clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (start) pending_q <= 1'b1;
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        if (y_q == Y_LAST) begin
                            y_q     <= '0;
                            cnt_q   <= '0;
                            state_q <= DRAIN;
                        end else begin
                            y_q <= y_q + 8'd1;
                        end
                    end else begin
                        x_q <= x_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (done_q) begin
                        done_q    <= 1'b0;
                        pending_q <= 1'b0;
                        busy_q    <= pending_q | start;
                        state_q   <= (pending_q | start) ? SCAN : IDLE;
                    end else begin
                        if (start) pending_q <= 1'b1;
                        if (cnt_q == DRAIN_LAST) begin
                            done_q <= 1'b1;
                            busy_q <= pending_q | start;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Coordinate delay line matching the renderers' read latency.
    logic [LATENCY-1:0]      vld_pipe_q;
    logic [LATENCY-1:0][7:0] xp_q;
    logic [LATENCY-1:0][6:0] yp_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe_q <= '0;
            xp_q       <= '0;
            yp_q       <= '0;
        end else begin
            vld_pipe_q[0] <= (state_q == SCAN);
            xp_q[0]       <= x_q;
            yp_q[0]       <= y_q[6:0];
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                xp_q[i]       <= xp_q[i-1];
                yp_q[i]       <= yp_q[i-1];
            end
        end
    end

    logic       plot_q, plot_d;
    logic [7:0] vx_q, vx_d;
    logic [6:0] vy_q, vy_d;
    logic [2:0] col_q, col_d;

    always_comb begin
        plot_d = vld_pipe_q[LATENCY-1];
        vx_d   = vx_q;
        vy_d   = vy_q;
        col_d  = col_q;
        if (plot_d) begin
            vx_d  = xp_q[LATENCY-1];
            vy_d  = yp_q[LATENCY-1];
            col_d = fgOpaque ? fgColor : bgColor;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot_q <= 1'b0;
            vx_q   <= '0;
            vy_q   <= '0;
            col_q  <= '0;
        end else begin
            plot_q <= plot_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            col_q  <= col_d;
        end
    end

    assign scanX     = x_q;
    assign scanY     = y_q;
    assign vgaX      = vx_q;
    assign vgaY      = vy_q;
    assign vgaColor  = col_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign frameDone = done_q;

endmodule

// File: doc/frame_plotter.md
Name: frame_plotter

Overview:
- Raster sequencer that sits directly upstream and downstream of the background and sprite renderers.
- Sweeps pixel coordinates (scanX, scanY) across the 160x120 play field and feeds them to the renderers.
- Realigns the coordinates with the renderers' registered ROM colour outputs and composites foreground over background.
- Drives the VGA adapter write port (x, y, colour, plot) one pixel per clock.
- Frames are triggered by the game's move tick.

Parameters:
X_MAX, 160, pixels per row; x counts 0..X_MAX-1
Y_MAX, 120, rows per frame; y counts 0..Y_MAX-1
LATENCY, 1, renderer read latency in clocks from scan coordinate to colour valid (1..4)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  frame request pulse (connected to moveClk)
bgColor  in  3  background renderer colour, valid LATENCY clocks after scan coordinate
fgColor  in  3  foreground sprite colour, same alignment as bgColor
fgOpaque  in  1  foreground pixel is opaque, same alignment as bgColor
scanX  out  8  x coordinate presented to renderers
scanY  out  8  y coordinate presented to renderers
vgaX  out  8  write x to VGA adapter
vgaY  out  7  write y to VGA adapter
vgaColor  out  3  write colour to VGA adapter
plot  out  1  VGA write enable
busy  out  1  frame in progress
frameDone  out  1  one-clock pulse after the final pixel of a frame is plotted

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; scanX, scanY, vgaX, vgaY, vgaColor = 0; plot, busy, frameDone = 0; pending=0; delay line valid bits cleared. Every register, including the delay line, resets.
- FSM states:
  - IDLE: scanX/scanY held at 0. start=1 -> SCAN on next edge; busy=1 from that edge.
  - SCAN: one coordinate issued per clock, raster order: x increments; at x=X_MAX-1, x wraps to 0 and y increments. After issuing (X_MAX-1, Y_MAX-1) -> DRAIN; scanX/scanY return to 0.
  - DRAIN: runs LATENCY+1 clocks so every in-flight pixel is plotted, then frameDone=1 for exactly one clock.
    - pending=0: -> IDLE; busy drops with the frameDone edge.
    - pending=1: -> SCAN, pending cleared, busy stays 1.
- Delay line: LATENCY-deep shift of {valid, x, y}. valid=1 only for coordinates issued in SCAN.
- Output register, loaded each clock from the delay line tail and the renderer inputs:
  - plot <= tail.valid
  - vgaX <= tail.x; vgaY <= tail.y[6:0]
  - vgaColor <= fgOpaque ? fgColor : bgColor
  - When tail.valid=0: plot=0, and vgaX/vgaY/vgaColor hold their previous values.
- Latency: coordinate issued in clock t is plotted (plot=1) in clock t+LATENCY+1.
  - With LATENCY=1 and start sampled at edge 0: first issue in clock 1, first plot (0,0) in clock 3, last plot (159,119) in clock 19202, frameDone in clock 19203.
- Exactly X_MAX*Y_MAX plot pulses per frame. No coordinate is skipped or duplicated.
- start while busy (SCAN or DRAIN): pending<=1. Further starts while pending are absorbed (max one queued frame). A start in the same clock as frameDone sets pending.
- No back-to-back overlap: the next frame's first issue follows frameDone.
- Widths: x and y counters 8 bits. Row and last-pixel compares use X_MAX-1 and Y_MAX-1. No arithmetic overflow is possible for legal parameters.
- Reset mid-frame: all outputs are 0 immediately (asynchronous); no partial plot pulse after release; pending is lost.

Test Plan:
- Reset: hold resetn=0 for 3 clocks mid-SCAN -> plot=0, busy=0, scanX=scanY=0, frameDone=0 immediately. After release with no start: remains IDLE for 100 clocks with plot=0.
- Single frame, LATENCY=1: start pulse at edge 0; renderer model returns bgColor={x[0],y[0],1}, fgOpaque=0 -> exactly 19200 plot pulses; first (0,0,colour 001) in clock 3; last (159,119,colour 111) in clock 19202; frameDone in clock 19203 only; busy low from that clock on.
- Compositing: fgOpaque=1 with fgColor=3'b100 at x=80 only, all rows -> column 80 plotted 100, every other pixel plotted bgColor; 120 plots with colour 100.
- Queued start: second start at scan pixel 5000, plus a third start at pixel 9000 -> exactly 2 frames (38400 plots), one frameDone per frame; the second frame's first issue is in the clock after the first frameDone.
- LATENCY=3: renderer model delayed 3 clocks -> every plotted (vgaX, vgaY) matches the colour model with no offset; first plot in clock 5; frameDone in clock 19205.
- Reset at scan pixel 10000, then release and start -> new frame begins at (0,0); 19200 plots; no stale delay-line pixel is plotted.
